// File: rtl/cpu_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_pkg
//   Shared types and constants for the lab CPU run controller.
//   - run_state_t       : controller FSM state, 3-bit encoding
//   - RUN_CNT_UNLIMITED : MAX_CYCLES value that disables the cycle budget
// ---------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        STEP      = 3'd4,
        DONE      = 3'd5
    } run_state_t;

    localparam int RUN_CNT_UNLIMITED = 0;

endpackage

// File: rtl/cpu_run_ctrl_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
//   Registered rising-edge detector. The input is captured in one register
//   and the pulse itself is registered, so a rise on d shows up as a
//   one-cycle pulse on rise in the cycle after d goes high.
//   Ports:
//     clk   in  system clock
//     reset in  synchronous, active-high reset (clears both registers)
//     d     in  level input
//     rise  out one-cycle pulse per 0->1 transition of d
// ---------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for the lab CPU. Issues the CPU reset pulse at run start,
//   gates the CPU with a per-cycle clock enable, counts enabled cycles and
//   stops the run on HALT or budget exhaustion. Supports free-run and
//   single-step operation.
//
//   Optional feature: define CPU_RUN_CTRL_BREAKPOINT_EN to add a PC
//   breakpoint comparator (ports pc, bp_addr, bp_valid; parameter PC_W).
//
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous, active-high controller reset
//     start        in   level; rising edge begins a run (from IDLE/DONE)
//     step_mode    in   1 = single-step, 0 = free-run
//     step_req     in   level; each rising edge grants one cycle in STEP_WAIT
//     halt_in      in   CPU executed HALT (looked at only on enabled cycles)
//     pc           in   CPU program counter        (breakpoint build only)
//     bp_addr      in   breakpoint address          (breakpoint build only)
//     bp_valid     in   breakpoint armed            (breakpoint build only)
//     cpu_reset    out  active-high CPU reset
//     cpu_en       out  CPU clock enable
//     cycle_count  out  enabled cycles since the last run start
//     done         out  run ended by HALT
//     timeout      out  run ended by cycle budget
// ---------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 500,
    parameter int CNT_W      = 16
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    ,
    parameter int PC_W       = 9
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt_in,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
`endif
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             timeout
);

    localparam bit               BUDGET_EN = (MAX_CYCLES != RUN_CNT_UNLIMITED);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);
    localparam int               RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);

    run_state_t       state;
    run_state_t       state_next;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] count_inc;
    logic             budget_hit;
    logic             bp_hit;
    logic             start_rise;
    logic             step_rise;

    edge_det u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .rise  (start_rise)
    );

    edge_det u_step_edge (
        .clk   (clk),
        .reset (reset),
        .d     (step_req),
        .rise  (step_rise)
    );

    // Moore decode: both CPU controls depend on state only.
    assign cpu_reset = (state == IDLE) || (state == RESET);
    assign cpu_en    = (state == RUN)  || (state == STEP);

    assign count_inc  = cycle_count + CNT_W'(1);
    assign budget_hit = BUDGET_EN && (count_inc == MAX_CNT);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Set on the way out of STEP_WAIT so the first enabled cycle afterwards
    // can execute past the breakpoint address instead of trapping again.
    logic bp_suppress;

    assign bp_hit = (state == RUN) && bp_valid && (pc == bp_addr) && !bp_suppress;

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_suppress <= 1'b0;
        end else if ((state == STEP_WAIT) && (state_next != STEP_WAIT)) begin
            bp_suppress <= 1'b1;
        end else if (cpu_en) begin
            bp_suppress <= 1'b0;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    // NOTE: state_next gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_rise) state_next = RESET;
            end
            RESET: begin
                if (rst_cnt == RST_LAST) state_next = step_mode ? STEP_WAIT : RUN;
            end
            RUN: begin
                // halt > breakpoint > budget > step_mode request
                if (halt_in)         state_next = DONE;
                else if (bp_hit)     state_next = STEP_WAIT;
                else if (budget_hit) state_next = DONE;
                else if (step_mode)  state_next = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (step_rise)       state_next = STEP;
                else if (!step_mode) state_next = RUN;
            end
            STEP: begin
                state_next = (halt_in || budget_hit) ? DONE : STEP_WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state <= state_next;

            // Counts cycles spent in RESET; idles at zero everywhere else.
            if (state == RESET) rst_cnt <= rst_cnt + RC_W'(1);
            else                rst_cnt <= '0;

            if (((state == IDLE) || (state == DONE)) && start_rise) begin
                cycle_count <= '0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end else if (cpu_en) begin
                cycle_count <= count_inc;
                // Entering DONE from an enabled cycle: HALT wins over budget.
                if (state_next == DONE) begin
                    done    <= halt_in;
                    timeout <= ~halt_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Bench for cpu_run_ctrl. Two instances share stimulus: dut (MAX_CYCLES=10)
//   and dut4 (MAX_CYCLES=4). Each scenario task pushes the expected output
//   snapshot for a cycle into a queue as it drives that cycle, then pops and
//   compares at the falling edge. Breakpoint scenario is built only when
//   CPU_RUN_CTRL_BREAKPOINT_EN is defined.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [15:0] cnt;
        logic        dn;
        logic        to;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_in = 1'b0;

    logic        cpu_reset, cpu_en, done, timeout;
    logic [15:0] cycle_count;
    logic        cpu_reset4, cpu_en4, done4, timeout4;
    logic [15:0] cycle_count4;

    snap_t       obs_m;
    snap_t       obs_4;
    snap_t       sb_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic [8:0]  pc = '0;
    logic [8:0]  bp_addr = '0;
    logic        bp_valid = 1'b0;

    // Minimal CPU stand-in: PC clears under cpu_reset, advances per enabled cycle.
    always @(posedge clk) begin
        if (cpu_reset)   pc <= '0;
        else if (cpu_en) pc <= pc + 9'd1;
    end
`endif

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(10), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .halt_in     (halt_in),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
`endif
        .cpu_reset   (cpu_reset),
        .cpu_en      (cpu_en),
        .cycle_count (cycle_count),
        .done        (done),
        .timeout     (timeout)
    );

    cpu_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(4), .CNT_W(16)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .halt_in     (halt_in),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (1'b0),
`endif
        .cpu_reset   (cpu_reset4),
        .cpu_en      (cpu_en4),
        .cycle_count (cycle_count4),
        .done        (done4),
        .timeout     (timeout4)
    );

    assign obs_m = {cpu_reset,  cpu_en,  cycle_count,  done,  timeout};
    assign obs_4 = {cpu_reset4, cpu_en4, cycle_count4, done4, timeout4};

    function automatic snap_t mk(input logic r, input logic e, input int c,
                                 input logic d, input logic t);
        snap_t s;
        s.rst = r;
        s.en  = e;
        s.cnt = 16'(c);
        s.dn  = d;
        s.to  = t;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("rst=%b en=%b cnt=%0d done=%b timeout=%b",
                         s.rst, s.en, s.cnt, s.dn, s.to);
    endfunction

    // Synchronous reset for one edge; leaves the bench just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_m !== mk(1, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state dut: got %s, expected %s", fmt(obs_m), fmt(mk(1, 0, 0, 0, 0)));
        end
        n_checks++;
        if (obs_4 !== mk(1, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state dut4: got %s, expected %s", fmt(obs_4), fmt(mk(1, 0, 0, 0, 0)));
        end
        @(posedge clk); #1;
    endtask

    // Reset in cycle 0, start rises at cycle 5, budget of 10 expires.
    // A start re-edge during RUN (cycles 12-14) must be ignored.
    task automatic test_budget();
        snap_t e;
        for (int i = 0; i < 24; i++) begin
            reset = (i == 0);
            start = (i >= 5) && !(i >= 12 && i < 14);
            if (i <= 8)       sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 18) sb_q.push_back(mk(0, 1, i - 9, 0, 0));
            else              sb_q.push_back(mk(0, 0, 10, 0, 1));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_m !== e) begin
                n_fail++;
                $display("FAIL budget cycle %0d: got %s, expected %s", i, fmt(obs_m), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    // Restart from DONE, halt on the 4th enabled cycle, then restart again.
    task automatic test_halt();
        snap_t e;
        for (int i = 0; i < 19; i++) begin
            start   = (i >= 2) && !(i >= 11 && i < 13);
            halt_in = (i == 9);
            if (i <= 3)       sb_q.push_back(mk(0, 0, 10, 0, 1));
            else if (i <= 5)  sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 9)  sb_q.push_back(mk(0, 1, i - 6, 0, 0));
            else if (i <= 14) sb_q.push_back(mk(0, 0, 4, 1, 0));
            else if (i <= 16) sb_q.push_back(mk(1, 0, 0, 0, 0));
            else              sb_q.push_back(mk(0, 1, i - 17, 0, 0));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_m !== e) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %s, expected %s", i, fmt(obs_m), fmt(e));
            end
            @(posedge clk); #1;
        end
        halt_in = 1'b0;
    endtask

    // Single-step: a step_req edge during RESET is dropped, three spaced
    // pulses give three steps, a held level gives exactly one more.
    task automatic test_step();
        snap_t e;
        start = 1'b0; step_mode = 1'b1; step_req = 1'b0; halt_in = 1'b0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            start    = (i >= 2);
            step_req = (i == 4) || (i == 8) || (i == 13) || (i == 18) || (i >= 23);
            if (i <= 5)       sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 9)  sb_q.push_back(mk(0, 0, 0, 0, 0));
            else if (i == 10) sb_q.push_back(mk(0, 1, 0, 0, 0));
            else if (i <= 14) sb_q.push_back(mk(0, 0, 1, 0, 0));
            else if (i == 15) sb_q.push_back(mk(0, 1, 1, 0, 0));
            else if (i <= 19) sb_q.push_back(mk(0, 0, 2, 0, 0));
            else if (i == 20) sb_q.push_back(mk(0, 1, 2, 0, 0));
            else if (i <= 24) sb_q.push_back(mk(0, 0, 3, 0, 0));
            else if (i == 25) sb_q.push_back(mk(0, 1, 3, 0, 0));
            else              sb_q.push_back(mk(0, 0, 4, 0, 0));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_m !== e) begin
                n_fail++;
                $display("FAIL step cycle %0d: got %s, expected %s", i, fmt(obs_m), fmt(e));
            end
            @(posedge clk); #1;
        end
        step_mode = 1'b0;
        step_req  = 1'b0;
    endtask

    // MAX_CYCLES=4 with HALT on the 4th enabled cycle: halt wins.
    task automatic test_halt_vs_budget();
        snap_t e;
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_in = 1'b0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            start   = (i >= 2);
            halt_in = (i == 9);
            if (i <= 5)      sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 9) sb_q.push_back(mk(0, 1, i - 6, 0, 0));
            else             sb_q.push_back(mk(0, 0, 4, 1, 0));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_4 !== e) begin
                n_fail++;
                $display("FAIL halt_vs_budget cycle %0d: got %s, expected %s", i, fmt(obs_4), fmt(e));
            end
            @(posedge clk); #1;
        end
        halt_in = 1'b0;
    endtask

    // Reset asserted while RUN shows cycle_count=7 aborts to IDLE next cycle.
    task automatic test_mid_reset();
        snap_t e;
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_in = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            start = (i >= 2) && (i < 13);
            reset = (i == 13);
            if (i <= 5)       sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 13) sb_q.push_back(mk(0, 1, i - 6, 0, 0));
            else              sb_q.push_back(mk(1, 0, 0, 0, 0));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_m !== e) begin
                n_fail++;
                $display("FAIL mid_reset cycle %0d: got %s, expected %s", i, fmt(obs_m), fmt(e));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint at 0x005 traps after pc=5 executes; one step runs pc=6;
    // dropping step_mode resumes RUN.
    task automatic test_breakpoint();
        snap_t e;
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_in = 1'b0;
        bp_addr = 9'h005; bp_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            start     = (i >= 2);
            step_mode = (i >= 12) && (i < 18);
            step_req  = (i == 14);
            if (i <= 5)       sb_q.push_back(mk(1, 0, 0, 0, 0));
            else if (i <= 11) sb_q.push_back(mk(0, 1, i - 6, 0, 0));
            else if (i <= 15) sb_q.push_back(mk(0, 0, 6, 0, 0));
            else if (i == 16) sb_q.push_back(mk(0, 1, 6, 0, 0));
            else if (i <= 18) sb_q.push_back(mk(0, 0, 7, 0, 0));
            else              sb_q.push_back(mk(0, 1, i - 12, 0, 0));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_m !== e) begin
                n_fail++;
                $display("FAIL breakpoint cycle %0d: got %s, expected %s", i, fmt(obs_m), fmt(e));
            end
            if (i == 16) begin
                n_checks++;
                if (pc !== 9'd6) begin
                    n_fail++;
                    $display("FAIL breakpoint_step_pc: got pc=%0d, expected pc=6", pc);
                end
            end
            @(posedge clk); #1;
        end
        bp_valid  = 1'b0;
        step_mode = 1'b0;
        start     = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_budget();
        test_halt();
        test_step();
        test_halt_vs_budget();
        test_mid_reset();
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
